rr_pio_gen: RTL and testbench

Parametrised Avalon-MM slave PIO for the rr subsystem, replacing the fixed 8-bit output-only PIO. It provides a WIDTH-bit output port with atomic bit set and clear, a synchronised WIDTH-bit input port, per-bit edge capture and a maskable level interrupt. It sits on the Nios data master bus alongside the other rr peripherals.

---
 rtl/rr_pio_pkg.sv | 17 +
 rtl/rr_pio_sync.sv | 31 +++
 rtl/rr_pio_gen.sv | 123 ++++++++++++
 tb/tb_rr_pio_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pio_pkg.sv
// rtl/rr_pio_pkg.sv - Shared constants for the rr PIO: register map, edge encodings, bus width
package rr_pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUT      = 3'd1;
  localparam logic [2:0] ADDR_OUTSET   = 3'd2;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/rr_pio_sync.sv
// rtl/rr_pio_sync.sv - WIDTH-bit two-flop synchroniser for asynchronous input pins
module rr_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rr_pio_gen.sv
// rtl/rr_pio_gen.sv - Avalon-MM PIO: set/clear output, synchronised input, edge-capture irq
// Edge capture, mask and irq exist only when RR_PIO_GEN_IRQ_EN is defined.
module rr_pio_gen
  import rr_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > BUS_W) begin : g_width_check
    $error("rr_pio_gen: WIDTH must be in 1..32");
  end

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rd_w;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  rr_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (in_port),
    .q   (sync_w)
  );

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA, ADDR_OUT: out_d = wdata;
        ADDR_OUTSET:         out_d = out_q | wdata;
        ADDR_OUTCLR:         out_d = out_q & ~wdata;
        default:             out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= RESET_VALUE[WIDTH-1:0];
    else       out_q <= out_d;
  end

  assign out_port = out_q;

`ifdef RR_PIO_GEN_IRQ_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       arm_q, arm_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_raw, edge_w, clr_w;

  always_comb begin
    prev_d = sync_w;
    arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    case (EDGE_TYPE)
      EDGE_RISE: edge_raw = sync_w & ~prev_q;
      EDGE_FALL: edge_raw = ~sync_w & prev_q;
      default:   edge_raw = sync_w ^ prev_q;
    endcase
    // Suppress edges while the synchroniser is still filling after reset.
    edge_w = (arm_q == 2'd3) ? edge_raw : '0;
    clr_w  = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;
    cap_d  = (cap_q & ~clr_w) | edge_w;
    mask_d = (wr && address == ADDR_IRQ_MASK) ? wdata : mask_q;
    irq_d  = |(cap_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      arm_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      arm_q  <= arm_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA:     rd_w = sync_w;
      ADDR_OUT:      rd_w = out_q;
`ifdef RR_PIO_GEN_IRQ_EN
      ADDR_IRQ_MASK: rd_w = mask_q;
      ADDR_EDGE_CAP: rd_w = cap_q;
`endif
      default:       rd_w = '0;
    endcase
  end

  assign readdata = BUS_W'(rd_w);

endmodule

// File: tb/tb_rr_pio_gen.sv
// tb/tb_rr_pio_gen.sv - Directed self-checking bench for rr_pio_gen (irq tests need RR_PIO_GEN_IRQ_EN)
module tb_rr_pio_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  rr_pio_gen #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; write is sampled at the next posedge; returns at the following negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [31:0] exp_r;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_port !== 8'hA5) begin
      miscompares++;
      $display("FAIL reset_out_port: got %h expected %h", out_port, 8'hA5);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    for (int a = 0; a < 8; a++) begin
      exp_r = (a == 1) ? 32'hA5 : 32'h0;
      rd(3'(a), r);
      vectors++;
      if (r !== exp_r) begin
        miscompares++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", a, r, exp_r);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_set_clear;
    logic [31:0] r;
    wr(3'd1, 32'h0F);
    vectors++;
    if (out_port !== 8'h0F) begin
      miscompares++;
      $display("FAIL out_write: got %h expected %h", out_port, 8'h0F);
    end
    wr(3'd2, 32'hF0);
    vectors++;
    if (out_port !== 8'hFF) begin
      miscompares++;
      $display("FAIL outset: got %h expected %h", out_port, 8'hFF);
    end
    wr(3'd3, 32'h81);
    vectors++;
    if (out_port !== 8'h7E) begin
      miscompares++;
      $display("FAIL outclr: got %h expected %h", out_port, 8'h7E);
    end
    rd(3'd2, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL outset_read: got %h expected 0", r);
    end
    rd(3'd3, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL outclr_read: got %h expected 0", r);
    end
    rd(3'd1, r);
    vectors++;
    if (r !== 32'h7E) begin
      miscompares++;
      $display("FAIL out_read: got %h expected %h", r, 32'h7E);
    end
    wr(3'd6, 32'hFF);
    vectors++;
    if (out_port !== 8'h7E) begin
      miscompares++;
      $display("FAIL reserved_write: got %h expected %h", out_port, 8'h7E);
    end
    wr(3'd0, 32'hFFFF_FF3C);
    rd(3'd1, r);
    vectors++;
    if (r !== 32'h3C) begin
      miscompares++;
      $display("FAIL data_write_upper_ignored: got %h expected %h", r, 32'h3C);
    end
  endtask

  task automatic test_input_edge;
    logic [31:0] r;
`ifdef RR_PIO_GEN_IRQ_EN
    wr(3'd4, 32'h04);
    rd(3'd4, r);
    vectors++;
    if (r !== 32'h04) begin
      miscompares++;
      $display("FAIL mask_read: got %h expected %h", r, 32'h04);
    end
`endif
    in_port = 8'h04;
    @(negedge clk);
    rd(3'd0, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL data_after_k: got %h expected 0", r);
    end
    @(negedge clk);
    rd(3'd0, r);
    vectors++;
    if (r !== 32'h04) begin
      miscompares++;
      $display("FAIL data_after_k1: got %h expected %h", r, 32'h04);
    end
`ifdef RR_PIO_GEN_IRQ_EN
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL cap_after_k1: got %h expected 0", r);
    end
    @(negedge clk);
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h04) begin
      miscompares++;
      $display("FAIL cap_after_k2: got %h expected %h", r, 32'h04);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_k2: got %b expected 0", irq);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_after_k3: got %b expected 1", irq);
    end
    // Raise bit 3, discard its capture, then drop it: the fall must not capture.
    in_port = 8'h0C;
    repeat (4) @(negedge clk);
    wr(3'd5, 32'h08);
    in_port = 8'h04;
    repeat (4) @(negedge clk);
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h04) begin
      miscompares++;
      $display("FAIL falling_no_capture: got %h expected %h", r, 32'h04);
    end
`endif
  endtask

  task automatic test_clear_race;
`ifdef RR_PIO_GEN_IRQ_EN
    logic [31:0] r;
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h04;
    repeat (2) @(negedge clk);
    wr(3'd5, 32'h04);
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h04) begin
      miscompares++;
      $display("FAIL race_cap: got %h expected %h", r, 32'h04);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL race_irq: got %b expected 1", irq);
    end
    wr(3'd5, 32'h04);
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_cap: got %h expected 0", r);
    end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_irq_same_edge: got %b expected 1", irq);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_irq_next_edge: got %b expected 0", irq);
    end
`endif
  endtask

  task automatic test_arming;
    logic [31:0] r;
    in_port = 8'hFF;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_port !== 8'hA5) begin
      miscompares++;
      $display("FAIL midreset_out_port: got %h expected %h", out_port, 8'hA5);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd(3'd5, r);
      vectors++;
      if (r !== 32'h0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL arming_cycle%0d: got cap=%h irq=%b expected cap=0 irq=0", c, r, irq);
      end
    end
    rd(3'd0, r);
    vectors++;
    if (r !== 32'hFF) begin
      miscompares++;
      $display("FAIL arming_data: got %h expected %h", r, 32'hFF);
    end
`ifdef RR_PIO_GEN_IRQ_EN
    in_port = 8'hFE;
    repeat (4) @(negedge clk);
    in_port = 8'hFF;
    repeat (4) @(negedge clk);
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h01) begin
      miscompares++;
      $display("FAIL armed_capture: got %h expected %h", r, 32'h01);
    end
`endif
  endtask

  task automatic test_macro_off;
`ifndef RR_PIO_GEN_IRQ_EN
    logic [31:0] r;
    wr(3'd4, 32'hFF);
    for (int c = 0; c < 4; c++) begin
      in_port = (c % 2 == 0) ? 8'h00 : 8'hFF;
      repeat (3) @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin
        miscompares++;
        $display("FAIL off_irq_%0d: got %b expected 0", c, irq);
      end
    end
    rd(3'd4, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL off_mask_read: got %h expected 0", r);
    end
    rd(3'd5, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL off_cap_read: got %h expected 0", r);
    end
`endif
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;
    test_reset;
    repeat (4) @(negedge clk);
    test_set_clear;
    test_input_edge;
    test_clear_race;
    test_arming;
    test_macro_off;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
